// File: rtl/cpu_pkg.sv
// Shared constants and state type for the shared-resource arbiters.
package cpu_pkg;

    localparam int NREQ = 16;
    localparam int SELW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set-bit picker: lowest requester index at or after ptr, wrapping.
module rr_pick
    import cpu_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [NREQ-1:0] w_rot;
    logic [SELW-1:0] w_off;

    // Rotate so ptr lands on bit 0, priority-encode, then add ptr back.
    assign w_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SELW'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = ptr + w_off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 16:1 mux select lines, with optional hold limit
// and one idle bubble between owners.
module mux_rr_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic            sel3,
    output logic            sel2,
    output logic            sel1,
    output logic            sel0,
    output logic [SELW-1:0] ptr
);

    localparam int unsigned CntW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t      r_state;
    logic [NREQ-1:0] r_gnt;
    logic            r_gnt_valid;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_ptr;
    logic [CntW-1:0] r_cnt;

    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic            w_hold_ok;

    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    if (MAX_HOLD == 0) begin : g_nolimit
        assign w_hold_ok = 1'b1;
    end else begin : g_limit
        assign w_hold_ok = (r_cnt < CntW'(MAX_HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_sel       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= GRANT;
                        r_gnt       <= NREQ'(1) << w_idx;
                        r_gnt_valid <= 1'b1;
                        r_sel       <= w_idx;
                        r_cnt       <= CntW'(1);
                    end
                end
                GRANT: begin
                    if (req[r_sel] && w_hold_ok) begin
                        if (r_cnt != {CntW{1'b1}}) begin
                            r_cnt <= r_cnt + CntW'(1);
                        end
                    end else begin
                        // r_sel is left alone so the mux output stays stable in the bubble.
                        r_state     <= IDLE;
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_sel + SELW'(1);
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign sel3      = r_sel[3];
    assign sel2      = r_sel[2];
    assign sel1      = r_sel[1];
    assign sel0      = r_sel[0];
    assign ptr       = r_ptr;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: three arbiters (hold limits 8, 3, 0) share one stimulus stream.
module tb_mux_rr_arbiter;

    localparam int NI = 3;
    localparam logic [15:0] MUX_DATA = 16'hA5C3;

    function automatic int hold_of(input int g);
        return (g == 0) ? 8 : (g == 1) ? 3 : 0;
    endfunction

    typedef struct packed {
        logic        valid;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic [3:0]  ptr;
        logic [3:0]  owner;
    } exp_t;
    typedef exp_t [NI-1:0] exp_all_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;

    wire [15:0] w_gnt [NI];
    wire        w_gv  [NI];
    wire [3:0]  w_sel [NI];
    wire [3:0]  w_ptr [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mux_rr_arbiter #(.MAX_HOLD(hold_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req       (req),
            .gnt       (w_gnt[g]),
            .gnt_valid (w_gv[g]),
            .sel3      (w_sel[g][3]),
            .sel2      (w_sel[g][2]),
            .sel1      (w_sel[g][1]),
            .sel0      (w_sel[g][0]),
            .ptr       (w_ptr[g])
        );
    end

    // Reference model: who owns the mux, how long, and where the next search starts.
    int m_owner [NI];
    int m_held  [NI];
    int m_start [NI];
    int m_last  [NI];

    exp_all_t sbq[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic model_step(input int k, input logic r, input logic [15:0] rq);
        if (r) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_start[k] = 0;
            m_last[k]  = 0;
        end else if (m_owner[k] < 0) begin
            for (int i = 0; i < 16; i++) begin
                if (m_owner[k] < 0 && rq[(m_start[k] + i) % 16]) begin
                    m_owner[k] = (m_start[k] + i) % 16;
                    m_held[k]  = 1;
                    m_last[k]  = m_owner[k];
                end
            end
        end else if (rq[m_owner[k]] && (hold_of(k) == 0 || m_held[k] < hold_of(k))) begin
            m_held[k] = m_held[k] + 1;
        end else begin
            m_start[k] = (m_owner[k] + 1) % 16;
            m_owner[k] = -1;
        end
    endtask

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.valid = (m_owner[k] >= 0);
        e.gnt   = e.valid ? (16'd1 << m_owner[k]) : 16'd0;
        e.sel   = 4'(m_last[k]);
        e.ptr   = 4'(m_start[k]);
        e.owner = 4'(m_last[k]);
        return e;
    endfunction

    task automatic drive(input logic r, input logic [15:0] rq);
        exp_all_t ea;
        @(negedge clk);
        rst = r;
        req = rq;
        for (int k = 0; k < NI; k++) begin
            model_step(k, r, rq);
            ea[k] = expect_of(k);
        end
        sbq.push_back(ea);
    endtask

    task automatic hold_req(input logic [15:0] rq, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rq);
    endtask

    // Monitor: one expected record per sampled edge, checked 1 time unit after it.
    initial begin
        exp_all_t    ea;
        exp_t        e;
        logic [15:0] data_v;
        logic        inv_ok;
        data_v = MUX_DATA;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                ea = sbq.pop_front();
                for (int k = 0; k < NI; k++) begin
                    e = ea[k];
                    n_total++;
                    if (w_gv[k] === e.valid && w_gnt[k] === e.gnt && w_sel[k] === e.sel
                        && w_ptr[k] === e.ptr) begin
                        n_pass++;
                    end else begin
                        $display("FAIL outputs inst%0d t=%0t: got gv=%b gnt=%h sel=%h ptr=%h want gv=%b gnt=%h sel=%h ptr=%h",
                                 k, $time, w_gv[k], w_gnt[k], w_sel[k], w_ptr[k],
                                 e.valid, e.gnt, e.sel, e.ptr);
                    end
                    inv_ok = $onehot0(w_gnt[k]) && (w_gv[k] === |w_gnt[k])
                             && (!w_gv[k] || w_gnt[k][w_sel[k]] === 1'b1);
                    n_total++;
                    if (inv_ok) n_pass++;
                    else $display("FAIL invariant inst%0d t=%0t: got gv=%b gnt=%h sel=%h want one-hot grant matching sel",
                                  k, $time, w_gv[k], w_gnt[k], w_sel[k]);
                    if (e.valid) begin
                        n_total++;
                        if (data_v[w_sel[k]] === data_v[e.owner]) n_pass++;
                        else $display("FAIL mux_res inst%0d t=%0t: got %b want %b (owner %0d)",
                                      k, $time, data_v[w_sel[k]], data_v[e.owner], e.owner);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] rq;
        int          n;
        for (int k = 0; k < NI; k++) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_start[k] = 0;
            m_last[k]  = 0;
        end
        // Reset then single request from requester 2, then release.
        drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0000);
        hold_req(16'h0000, 2);
        hold_req(16'h0004, 4);
        hold_req(16'h0000, 3);
        // Fairness between 0 and 15 across the wrap.
        drive(1'b1, 16'h0000);
        hold_req(16'h8001, 40);
        // Forced release between 4 and 5.
        drive(1'b1, 16'h0000);
        hold_req(16'h0030, 20);
        // Everyone requesting for 100 cycles.
        drive(1'b1, 16'h0000);
        hold_req(16'hFFFF, 100);
        // Reset while requester 9 owns the mux.
        drive(1'b1, 16'h0000);
        hold_req(16'h0200, 3);
        drive(1'b1, 16'h0200);
        hold_req(16'h0200, 4);
        // Each requester in turn, for the mux end-to-end view.
        drive(1'b1, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            rq = 16'd1 << i;
            hold_req(rq, 3);
        end
        // Randomized traffic with occasional resets.
        for (int s = 0; s < 120; s++) begin
            case ($urandom_range(0, 3))
                0:       rq = 16'h0000;
                1:       rq = 16'd1 << $urandom_range(0, 15);
                2:       rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: rq = 16'($urandom);
            endcase
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 49) == 0) drive(1'b1, rq);
                else drive(1'b0, rq);
                if ($urandom_range(0, 3) == 0) rq = rq ^ (16'd1 << $urandom_range(0, 15));
            end
        end
        // Let the monitor drain, with a bound.
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        n_total++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d records left want 0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
